// File: rtl/regfile_wb_pkg.sv
// Shared CPU constants and small helpers for the register file and its
// pending-write scoreboard.
package regfile_wb_pkg;

    localparam int NREGS  = 32;
    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_AW-1:0] R0_IDX = 5'd0;

    // True when the write-back this cycle targets a real register equal to addr.
    function automatic logic wb_hits(
        input logic              rw,
        input logic [REG_AW-1:0] dest,
        input logic [REG_AW-1:0] addr
    );
        return rw && (dest != R0_IDX) && (dest == addr);
    endfunction

endpackage

// File: rtl/regfile_wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus the operand-hazard
// stall. Bypass decisions are made by the register file and passed in.
module regfile_scoreboard
    import regfile_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic              wb_rw,
    input  logic [REG_AW-1:0] iss_dest,
    input  logic              iss_rw,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
    input  logic              ra_used,
    input  logic              rb_used,
    input  logic              bypass_a,
    input  logic              bypass_b,
    output logic              stall,
    output logic [NREGS-1:0]  busy
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;
    logic             stall_s;
    logic             hazard_a_s;
    logic             hazard_b_s;
    logic             set_s;
    logic             clr_s;

    // Operand hazard: a used operand waits on a write that is not arriving now.
    always_comb begin
        hazard_a_s = ra_used && busy_r[ra_addr] && !bypass_a;
        hazard_b_s = rb_used && busy_r[rb_addr] && !bypass_b;
        if (rst) begin
            stall_s = 1'b0;
        end else if (iss_valid) begin
            stall_s = hazard_a_s || hazard_b_s;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Next busy vector: clear on write-back first, then set on issue so the
    // newer pending write wins when both hit the same register.
    always_comb begin
        set_s      = iss_valid && !stall_s && iss_rw && (iss_dest != R0_IDX);
        clr_s      = wb_rw && (wb_dest != R0_IDX);
        busy_nxt_s = busy_r;
        if (clr_s) begin
            busy_nxt_s[wb_dest] = 1'b0;
        end else begin
            busy_nxt_s[wb_dest] = busy_r[wb_dest];
        end
        if (set_s) begin
            busy_nxt_s[iss_dest] = 1'b1;
        end else begin
            busy_nxt_s[iss_dest] = busy_nxt_s[iss_dest];
        end
        busy_nxt_s[R0_IDX] = 1'b0;
    end

    // Busy bit storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {NREGS{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign stall = stall_s;
    assign busy  = busy_r;

endmodule

// File: rtl/regfile_wb.sv
// 32 x 32 register file with write-back port, same-cycle bypass to both read
// ports, and a pending-write scoreboard that raises stall on operand hazards.
module regfile_wb
    import regfile_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic              wb_rw,
    input  logic [REG_AW-1:0] iss_dest,
    input  logic              iss_rw,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
    input  logic              ra_used,
    input  logic              rb_used,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              stall,
    output logic [NREGS-1:0]  busy
);

    logic [DATA_W-1:0] mem_r [NREGS];
    logic [DATA_W-1:0] ra_data_s;
    logic [DATA_W-1:0] rb_data_s;
    logic              bypass_a_s;
    logic              bypass_b_s;
    logic              wb_en_s;

    assign wb_en_s    = wb_rw && (wb_dest != R0_IDX);
    assign bypass_a_s = wb_hits(wb_rw, wb_dest, ra_addr);
    assign bypass_b_s = wb_hits(wb_rw, wb_dest, rb_addr);

    // Array write port; R0 is never written so it stays zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wb_en_s) begin
            mem_r[wb_dest] <= wb_data;
        end
    end

    // Read port A: zero while in reset or for R0, bypass, else array.
    always_comb begin
        ra_data_s = {DATA_W{1'b0}};
        if (rst) begin
            ra_data_s = {DATA_W{1'b0}};
        end else if (ra_addr == R0_IDX) begin
            ra_data_s = {DATA_W{1'b0}};
        end else if (bypass_a_s) begin
            ra_data_s = wb_data;
        end else begin
            ra_data_s = mem_r[ra_addr];
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        rb_data_s = {DATA_W{1'b0}};
        if (rst) begin
            rb_data_s = {DATA_W{1'b0}};
        end else if (rb_addr == R0_IDX) begin
            rb_data_s = {DATA_W{1'b0}};
        end else if (bypass_b_s) begin
            rb_data_s = wb_data;
        end else begin
            rb_data_s = mem_r[rb_addr];
        end
    end

    assign ra_data = ra_data_s;
    assign rb_data = rb_data_s;

    regfile_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wb_dest   (wb_dest),
        .wb_rw     (wb_rw),
        .iss_dest  (iss_dest),
        .iss_rw    (iss_rw),
        .iss_valid (iss_valid),
        .ra_addr   (ra_addr),
        .rb_addr   (rb_addr),
        .ra_used   (ra_used),
        .rb_used   (rb_used),
        .bypass_a  (bypass_a_s),
        .bypass_b  (bypass_b_s),
        .stall     (stall),
        .busy      (busy)
    );

endmodule
